// File: rtl/vme_cmd_pkg.sv
// ---------------------------------------------------------------------------
// vme_cmd_pkg
// Shared types and constants for the VME command arbiter and its users.
//   state_e                 : arbiter FSM states (IDLE, ISSUE, WAIT_DONE)
//   IDLE_CMD_DEFAULT        : command word parked on the engine when idle
//   RD_BIT_DEFAULT          : command-word bit that marks a read
//   TIMEOUT_CYCLES_DEFAULT  : completion watchdog limit
//   TIMEOUT_RDATA           : readback value reported on a watchdog expiry
// ---------------------------------------------------------------------------
package vme_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [31:0] IDLE_CMD_DEFAULT       = 32'h00F80000;
    localparam int          RD_BIT_DEFAULT         = 25;
    localparam int          TIMEOUT_CYCLES_DEFAULT = 1024;
    localparam logic [31:0] TIMEOUT_RDATA          = 32'hFFFFFFFF;

endpackage

// File: rtl/vme_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// vme_cmd_arbiter_if
// Command datapath between the arbiter and the single VME engine.
//   start           : command launch pulse              (arbiter -> engine)
//   vme_cmd_reg     : command word                      (arbiter -> engine)
//   vme_dat_reg_in  : write data                        (arbiter -> engine)
//   vme_cmd_rd      : engine ready to accept a command  (engine  -> arbiter)
//   vme_dat_wr      : completion strobe                 (engine  -> arbiter)
//   vme_dat_reg_out : readback data                     (engine  -> arbiter)
// Modports: master = arbiter side, slave = engine side.
// ---------------------------------------------------------------------------
interface vme_cmd_arbiter_if;

    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;

    modport master (
        output start, vme_cmd_reg, vme_dat_reg_in,
        input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out
    );

    modport slave (
        input  start, vme_cmd_reg, vme_dat_reg_in,
        output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority select: the first set request bit at or
// above ptr, wrapping past N-1 back to 0, wins. Reusable for any N-way
// single-winner arbitration (e.g. FIFO readout ports).
//   req   in  N  request vector
//   ptr   in  W  highest-priority index for this decision (must be < N)
//   gnt   out N  one-hot winner (all zero when no request)
//   idx   out W  binary index of the winner
//   valid out 1  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= N) s = s - N;
        return s;
    endfunction

    always_comb begin
        int j;
        // NOTE: every output gets a default before the scan so no path
        // leaves a value unassigned (which would infer a latch).
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = wrap_idx(int'(ptr), i);
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// vme_cmd_arbiter
// Shares the single VME command datapath among N_REQ requesters (host command
// stream, LVMB monitor poller, JTAG sequencer, ...). One command in flight at
// a time, round-robin fair, readback returned to the owning requester.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req            per-requester request level (drop after gnt)
//   req_cmd        packed command words, slice i = requester i
//   req_wdata      packed write data,    slice i = requester i
//   gnt            one-cycle one-hot grant pulse (coincides with start)
//   rsp_valid      one-cycle completion pulse
//   rsp_id         owner of the completed command
//   rsp_rd         completed command was a read (cmd[RD_BIT])
//   rsp_data       readback data, 0 for writes; holds between pulses
//   rsp_err        completion caused by watchdog expiry
//   busy           high whenever the FSM is not IDLE
//   vme            engine datapath (vme_cmd_arbiter_if.master)
//
// Optional feature: define VME_CMD_ARBITER_TIMEOUT_EN to enable a completion
// watchdog of TIMEOUT_CYCLES cycles in WAIT_DONE. Without it rsp_err is 0 and
// WAIT_DONE waits for the engine indefinitely.
// ---------------------------------------------------------------------------
module vme_cmd_arbiter
    import vme_cmd_pkg::*;
#(
    parameter  int          N_REQ          = 2,
    parameter  logic [31:0] IDLE_CMD       = IDLE_CMD_DEFAULT,
    parameter  int          RD_BIT         = RD_BIT_DEFAULT,
    parameter  int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    localparam int          ID_W           = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_cmd,
    input  logic [32*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_rd,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    vme_cmd_arbiter_if.master     vme
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 || RD_BIT < 0 || RD_BIT > 31)
    begin : g_bad_cfg
        $error("vme_cmd_arbiter: unsupported parameter set");
    end

    state_e            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;

    logic [N_REQ-1:0]  sel_gnt;
    logic [ID_W-1:0]   sel_idx;
    logic              sel_valid;

    logic              timed_out;
    logic              done;
    logic              cur_rd;
    logic [ID_W-1:0]   ptr_next;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .gnt   (sel_gnt),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // The command register doubles as the latched command while in flight.
    assign cur_rd   = vme.vme_cmd_reg[RD_BIT];
    assign ptr_next = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef VME_CMD_ARBITER_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Engine completion on the expiry cycle takes precedence over the watchdog.
    assign timed_out = (state == WAIT_DONE) && !vme.vme_dat_wr &&
                       (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign done = (state == WAIT_DONE) && (vme.vme_dat_wr || timed_out);

    // NOTE: all state and output registers use non-blocking assignments so
    // every read in this block sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ptr                <= '0;
            owner              <= '0;
            gnt                <= '0;
            busy               <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_id             <= '0;
            rsp_rd             <= 1'b0;
            rsp_data           <= '0;
            vme.start          <= 1'b0;
            vme.vme_cmd_reg    <= IDLE_CMD;
            vme.vme_dat_reg_in <= '0;
`ifdef VME_CMD_ARBITER_TIMEOUT_EN
            rsp_err            <= 1'b0;
            to_cnt             <= '0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            vme.start <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_valid && vme.vme_cmd_rd) begin
                        owner              <= sel_idx;
                        gnt                <= sel_gnt;
                        vme.start          <= 1'b1;
                        vme.vme_cmd_reg    <= req_cmd[int'(sel_idx)*32 +: 32];
                        vme.vme_dat_reg_in <= req_wdata[int'(sel_idx)*32 +: 32];
                        busy               <= 1'b1;
                        state              <= ISSUE;
                    end
                end

                // Launch cycle: start/gnt are already high; the engine cannot
                // have completed yet, so vme_dat_wr is not looked at here.
                ISSUE: begin
                    state <= WAIT_DONE;
`ifdef VME_CMD_ARBITER_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end

                WAIT_DONE: begin
                    if (done) begin
                        rsp_valid          <= 1'b1;
                        rsp_id             <= owner;
                        rsp_rd             <= cur_rd;
                        if (timed_out)   rsp_data <= TIMEOUT_RDATA;
                        else if (cur_rd) rsp_data <= vme.vme_dat_reg_out;
                        else             rsp_data <= '0;
                        ptr                <= ptr_next;
                        vme.vme_cmd_reg    <= IDLE_CMD;
                        vme.vme_dat_reg_in <= '0;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end
`ifdef VME_CMD_ARBITER_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef VME_CMD_ARBITER_TIMEOUT_EN
            rsp_err <= done && timed_out;
`endif
        end
    end

endmodule
